// File: rtl/adaptive_traffic_ctrl.sv
// Multi-phase round-robin traffic-light controller with density-scaled green time.
// Optional macro ATL_SKIP_EMPTY_EN: skip phases whose density is zero.
module adaptive_traffic_ctrl #(
  parameter int NUM_PHASES  = 4,
  parameter int CLK_PER_SEC = 50_000_000,
  parameter int DENS_W      = 3,
  parameter int CNT_W       = 6,
  parameter int G_MIN       = 5,
  parameter int G_STEP      = 2,
  parameter int G_MAX       = 20,
  parameter int Y_TIME      = 3,
  parameter int AR_TIME     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PHASES*DENS_W-1:0]   dens,
  output logic [3*NUM_PHASES-1:0]        lamp,
  output logic [$clog2(NUM_PHASES)-1:0]  phase_idx,
  output logic [1:0]                     state,
  output logic [CNT_W-1:0]               count_out,
  output logic                           tick
);

  localparam int PH_W = $clog2(NUM_PHASES);
  localparam int PC_W = $clog2(CLK_PER_SEC);
  localparam int GW   = CNT_W + DENS_W + 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(CLK_PER_SEC - 1);

  typedef enum logic [1:0] {
    S_GREEN  = 2'b00,
    S_YELLOW = 2'b01,
    S_ALLRED = 2'b10
  } state_t;

  logic [PC_W-1:0]         pc_q;
  state_t                  state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [3*NUM_PHASES-1:0] lamp_q;
  logic [PH_W-1:0]         next_ph;
  logic                    has_next;
  logic [DENS_W-1:0]       next_dens;
  int                      idx;

  function automatic logic [CNT_W-1:0] green_time(input logic [DENS_W-1:0] d);
    logic [GW-1:0] g;
    // Full-width sum so large densities clamp instead of wrapping.
    g = GW'(G_MIN) + GW'(d) * GW'(G_STEP);
    if (g > GW'(G_MAX)) g = GW'(G_MAX);
    return g[CNT_W-1:0];
  endfunction

  function automatic logic [3*NUM_PHASES-1:0] lamp_of(input state_t s, input logic [PH_W-1:0] ph);
    logic [3*NUM_PHASES-1:0] l;
    l = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      l[3*p +: 3] = 3'b100;
      if (PH_W'(p) == ph) begin
        case (s)
          S_GREEN:  l[3*p +: 3] = 3'b001;
          S_YELLOW: l[3*p +: 3] = 3'b010;
          default:  l[3*p +: 3] = 3'b100;
        endcase
      end
    end
    return l;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset)              pc_q <= '0;
    else if (pc_q == PC_LAST) pc_q <= '0;
    else                     pc_q <= pc_q + 1'b1;
  end

  assign tick = (pc_q == PC_LAST);

  always_comb begin
    idx = 0;
`ifdef ATL_SKIP_EMPTY_EN
    has_next = 1'b0;
    next_ph  = phase_q;
    // Walk backwards so the nearest non-empty phase is the one that sticks.
    for (int k = NUM_PHASES; k >= 1; k--) begin
      idx = int'(phase_q) + k;
      if (idx >= NUM_PHASES) idx = idx - NUM_PHASES;
      if (dens[idx*DENS_W +: DENS_W] != '0) begin
        has_next = 1'b1;
        next_ph  = PH_W'(idx);
      end
    end
`else
    has_next = 1'b1;
    next_ph  = (phase_q == PH_W'(NUM_PHASES - 1)) ? '0 : phase_q + 1'b1;
`endif
    next_dens = dens[int'(next_ph)*DENS_W +: DENS_W];
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    count_d = count_q;
    case (state_q)
      S_GREEN, S_YELLOW, S_ALLRED: begin
        if (tick) begin
          if (count_q > CNT_W'(1)) begin
            count_d = count_q - 1'b1;
          end else begin
            case (state_q)
              S_GREEN: begin
                state_d = S_YELLOW;
                count_d = CNT_W'(Y_TIME);
              end
              S_YELLOW: begin
                state_d = S_ALLRED;
                count_d = CNT_W'(AR_TIME);
              end
              default: begin
                if (has_next) begin
                  state_d = S_GREEN;
                  phase_d = next_ph;
                  count_d = green_time(next_dens);
                end else begin
                  count_d = CNT_W'(AR_TIME);
                end
              end
            endcase
          end
        end
      end
      default: begin
        state_d = S_ALLRED;
        phase_d = PH_W'(NUM_PHASES - 1);
        count_d = CNT_W'(AR_TIME);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_ALLRED;
      phase_q <= PH_W'(NUM_PHASES - 1);
      count_q <= CNT_W'(AR_TIME);
      lamp_q  <= {NUM_PHASES{3'b100}};
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      count_q <= count_d;
      lamp_q  <= lamp_of(state_d, phase_d);
    end
  end

  assign lamp      = lamp_q;
  assign phase_idx = phase_q;
  assign state     = state_q;
  assign count_out = count_q;

endmodule

// File: tb/tb_adaptive_traffic_ctrl.sv
// Directed bench for adaptive_traffic_ctrl (CLK_PER_SEC=4) plus a G_MAX=15 instance.
module tb_adaptive_traffic_ctrl;

  localparam int CPS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] dens;
  logic [11:0] lamp, c_lamp;
  logic [1:0]  phase_idx, c_phase;
  logic [1:0]  state, c_state;
  logic [5:0]  count_out, c_count;
  logic        tick, c_tick;
  bit          mon_en = 1'b0;
  int          n_chk  = 0;
  int          n_fail = 0;

  adaptive_traffic_ctrl #(.NUM_PHASES(4), .CLK_PER_SEC(CPS)) dut (
    .clk(clk), .reset(reset), .dens(dens), .lamp(lamp), .phase_idx(phase_idx),
    .state(state), .count_out(count_out), .tick(tick)
  );

  adaptive_traffic_ctrl #(.NUM_PHASES(4), .CLK_PER_SEC(CPS), .G_MAX(15)) u_clamp (
    .clk(clk), .reset(reset), .dens(dens), .lamp(c_lamp), .phase_idx(c_phase),
    .state(c_state), .count_out(c_count), .tick(c_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_lamp(input logic [1:0] st, input int ph);
    logic [11:0] l;
    l = 12'h924;
    l[3*ph +: 3] = (st == 2'd0) ? 3'b001 : (st == 2'd1) ? 3'b010 : 3'b100;
    return l;
  endfunction

  function automatic bit lamp_ok(input logic [11:0] l);
    int nr;
    bit ok;
    nr = 0;
    ok = 1'b1;
    for (int p = 0; p < 4; p++) begin
      case (l[3*p +: 3])
        3'b001, 3'b010: nr++;
        3'b100: ;
        default: ok = 1'b0;
      endcase
    end
    if (nr > 1) ok = 1'b0;
    return ok;
  endfunction

  always @(negedge clk) if (mon_en) check("lamp_legal", 32'(lamp_ok(lamp)), 32'd1);

  task automatic wait_tick();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < CPS + 2) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) check("tick_timeout", 32'(tick), 32'd1);
  endtask

  task automatic check_reset_state();
    check("rst_lamp",  32'(lamp),      32'h924);
    check("rst_state", 32'(state),     32'd2);
    check("rst_phase", 32'(phase_idx), 32'd3);
    check("rst_count", 32'(count_out), 32'd1);
    check("rst_tick",  32'(tick),      32'd0);
  endtask

  // Called at the negedge right after an interval starts; returns at the negedge after it ends.
  task automatic run_interval(input logic [1:0] st, input int ph, input int len,
                              input int stop_at, input int chg_at, input bit clamp_chk);
    check("int_state", 32'(state),     32'(st));
    check("int_phase", 32'(phase_idx), 32'(ph));
    check("int_count", 32'(count_out), 32'(len));
    check("int_lamp",  32'(lamp),      32'(exp_lamp(st, ph)));
    for (int r = len; r >= 1; r--) begin
      wait_tick();
      check("tick_count", 32'(count_out), 32'(r));
      if (clamp_chk && r == 5) begin
        check("clamp_green", 32'(c_state), 32'd0);
        check("clamp_last",  32'(c_count), 32'd1);
      end
      if (clamp_chk && r == 4) begin
        check("clamp_yellow", 32'(c_state), 32'd1);
        check("clamp_ycount", 32'(c_count), 32'd3);
      end
      if (r == chg_at) dens[3 +: 3] = 3'd0;
      if (r == stop_at) return;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
`ifdef ATL_SKIP_EMPTY_EN
    dens = {3'd0, 3'd4, 3'd0, 3'd0};
`else
    dens = {3'd0, 3'd1, 3'd7, 3'd3};
`endif
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    check_reset_state();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("tick_first", 32'(tick), 32'(i == 3));
    end
    check("pre_green_state", 32'(state), 32'd2);
    @(negedge clk);
`ifdef ATL_SKIP_EMPTY_EN
    run_interval(2'd0, 2, 13, 0, 0, 1'b0);
    run_interval(2'd1, 2, 3, 0, 0, 1'b0);
    run_interval(2'd2, 2, 1, 0, 0, 1'b0);
    dens = '0;
    run_interval(2'd0, 2, 13, 0, 0, 1'b0);
    run_interval(2'd1, 2, 3, 0, 0, 1'b0);
    run_interval(2'd2, 2, 1, 0, 0, 1'b0);
    run_interval(2'd2, 2, 1, 0, 0, 1'b0);
    run_interval(2'd2, 2, 1, 0, 0, 1'b0);
    run_interval(2'd2, 2, 1, 0, 0, 1'b0);
`else
    run_interval(2'd0, 0, 11, 0, 0, 1'b0);
    run_interval(2'd1, 0, 3, 0, 0, 1'b0);
    run_interval(2'd2, 0, 1, 0, 0, 1'b0);
    check("lamp0_red",  32'(lamp[2:0]), 32'd4);
    check("clamp_load", 32'(c_count),   32'd15);
    run_interval(2'd0, 1, 19, 0, 10, 1'b1);
    run_interval(2'd1, 1, 3, 0, 0, 1'b0);
    run_interval(2'd2, 1, 1, 0, 0, 1'b0);
    run_interval(2'd0, 2, 7, 6, 0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state();
    reset = 1'b1;
    run_interval(2'd2, 3, 1, 0, 0, 1'b0);
    run_interval(2'd0, 0, 11, 0, 0, 1'b0);
    run_interval(2'd1, 0, 3, 0, 0, 1'b0);
    run_interval(2'd2, 0, 1, 0, 0, 1'b0);
    run_interval(2'd0, 1, 5, 0, 0, 1'b0);
    run_interval(2'd1, 1, 3, 0, 0, 1'b0);
    run_interval(2'd2, 1, 1, 0, 0, 1'b0);
    run_interval(2'd0, 2, 7, 0, 0, 1'b0);
    run_interval(2'd1, 2, 3, 0, 0, 1'b0);
    run_interval(2'd2, 2, 1, 0, 0, 1'b0);
    run_interval(2'd0, 3, 5, 0, 0, 1'b0);
    run_interval(2'd1, 3, 3, 0, 0, 1'b0);
    run_interval(2'd2, 3, 1, 0, 0, 1'b0);
    run_interval(2'd0, 0, 11, 11, 0, 1'b0);
`endif
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
